// File: rtl/pattern_rotator_if.sv
`default_nettype none
// ============================================================================
// Module   : pattern_rotator_if
// Purpose  : Control, write-handshake and display bus of pattern_rotator.
//            master = command side (UART decoder), slave = the rotator.
// Signals  : run, dir, step_div, step_req   rotation control (master -> slave)
//            wr_valid, wr_addr, wr_data     slot write request (master -> slave)
//            wr_ready                       write can be accepted (slave -> master)
//            reg_out, pos, step_pulse       display bus and status (slave -> master)
// Revision : 1.0 - initial release
// ============================================================================
interface pattern_rotator_if #(
  parameter int WIDTH = 8,
  parameter int SIZE  = 16,
  parameter int DIV_W = 24
);
  localparam int AW = (SIZE > 1) ? $clog2(SIZE) : 1;

  logic                  run;
  logic                  dir;
  logic [DIV_W-1:0]      step_div;
  logic                  step_req;
  logic                  wr_valid;
  logic                  wr_ready;
  logic [AW-1:0]         wr_addr;
  logic [WIDTH-1:0]      wr_data;
  logic [WIDTH*SIZE-1:0] reg_out;
  logic [AW-1:0]         pos;
  logic                  step_pulse;

  modport master (
    output run, dir, step_div, step_req, wr_valid, wr_addr, wr_data,
    input  wr_ready, reg_out, pos, step_pulse
  );

  modport slave (
    input  run, dir, step_div, step_req, wr_valid, wr_addr, wr_data,
    output wr_ready, reg_out, pos, step_pulse
  );
endinterface
`default_nettype wire

// File: rtl/pattern_rotator.sv
`default_nettype none
// ============================================================================
// Module   : pattern_rotator
// Purpose  : Circular rotator of SIZE slots x WIDTH bits. Rotates left/right
//            every step_div+1 cycles while running; accepts slot writes and
//            single-step requests while paused.
// Ports    : clk     clock
//            rst_n   asynchronous active-low reset
//            bounce  (PATTERN_ROTATOR_BOUNCE_EN only) ping-pong enable
//            bus     pattern_rotator_if.slave (control, write, display bus)
// Options  : `define PATTERN_ROTATOR_BOUNCE_EN adds the bounce input and an
//            internal direction flag that reverses every SIZE-1 steps.
// Revision : 1.0 - initial release
// ============================================================================
module pattern_rotator #(
  parameter int WIDTH = 8,
  parameter int SIZE  = 16,
  parameter int DIV_W = 24
) (
  input  wire logic clk,
  input  wire logic rst_n,
`ifdef PATTERN_ROTATOR_BOUNCE_EN
  input  wire logic bounce,
`endif
  pattern_rotator_if.slave bus
);

  localparam int AW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [AW-1:0] c_last = AW'(SIZE - 1);

  typedef enum logic [0:0] {
    ST_PAUSED  = 1'b0,
    ST_RUNNING = 1'b1
  } state_t;

  state_t           r_state;
  logic             r_run;        // run as seen by the controller, one cycle late
  logic [DIV_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_slot [SIZE];
  logic [AW-1:0]    r_pos;
  logic             r_step_pulse;
  logic             r_wr_ready;

  logic             w_step;
  logic             w_dir;
  logic             w_wr_en;
  logic [AW-1:0]    w_pos_next;
  logic [WIDTH-1:0] w_rot  [SIZE];
  logic [WIDTH-1:0] w_next [SIZE];

`ifdef PATTERN_ROTATOR_BOUNCE_EN
  localparam logic [AW-1:0] c_turn = AW'(SIZE - 2);
  logic          r_bflag;
  logic [AW-1:0] r_bcnt;
  assign w_dir = bounce ? r_bflag : bus.dir;
`else
  assign w_dir = bus.dir;
`endif

  // Running steps on the prescaler; paused steps only on request. The >=
  // compare keeps a shrinking step_div from stranding the counter.
  assign w_step = (r_state == ST_RUNNING) ? (r_cnt >= bus.step_div) : bus.step_req;

  // Out-of-range addresses still complete the handshake but change nothing.
  assign w_wr_en = bus.wr_valid & r_wr_ready &
                   ({1'b0, bus.wr_addr} <= {1'b0, c_last});

  always_comb begin
    w_pos_next = r_pos;
    if (w_dir) w_pos_next = (r_pos == '0) ? c_last : (r_pos - AW'(1));
    else       w_pos_next = (r_pos == c_last) ? '0 : (r_pos + AW'(1));
  end

  always_comb begin
    for (int i = 0; i < SIZE; i++) begin
      if (w_dir) w_rot[i] = r_slot[(i + 1) % SIZE];
      else       w_rot[i] = r_slot[(i + SIZE - 1) % SIZE];
    end
  end

  // Rotation first, then the write lands on the rotated array.
  always_comb begin
    for (int i = 0; i < SIZE; i++) begin
      w_next[i] = w_step ? w_rot[i] : r_slot[i];
    end
    if (w_wr_en) w_next[bus.wr_addr] = bus.wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_PAUSED;
      r_run        <= 1'b0;
      r_cnt        <= '0;
      r_pos        <= '0;
      r_step_pulse <= 1'b0;
      r_wr_ready   <= 1'b0;
      for (int i = 0; i < SIZE; i++) r_slot[i] <= WIDTH'(i);
`ifdef PATTERN_ROTATOR_BOUNCE_EN
      r_bflag      <= 1'b0;
      r_bcnt       <= '0;
`endif
    end else begin
      r_run        <= bus.run;
      r_wr_ready   <= (r_state == ST_PAUSED);
      r_step_pulse <= w_step;
      for (int i = 0; i < SIZE; i++) r_slot[i] <= w_next[i];
      if (w_step) r_pos <= w_pos_next;

      case (r_state)
        ST_PAUSED: begin
          if (r_run) begin
            r_state <= ST_RUNNING;
            r_cnt   <= '0;
          end
        end
        ST_RUNNING: begin
          // A step due on the leaving edge still happens.
          if (w_step)     r_cnt <= '0;
          else if (r_run) r_cnt <= r_cnt + DIV_W'(1);
          if (!r_run) r_state <= ST_PAUSED;
        end
        default: r_state <= ST_PAUSED;
      endcase

`ifdef PATTERN_ROTATOR_BOUNCE_EN
      if (!bounce || (r_state == ST_PAUSED && r_run)) begin
        r_bflag <= bus.dir;
        r_bcnt  <= '0;
      end else if (w_step) begin
        if (r_bcnt == c_turn) begin
          r_bcnt  <= '0;
          r_bflag <= ~r_bflag;
        end else begin
          r_bcnt  <= r_bcnt + AW'(1);
        end
      end
`endif
    end
  end

  generate
    for (genvar gi = 0; gi < SIZE; gi++) begin : g_flat
      assign bus.reg_out[gi*WIDTH +: WIDTH] = r_slot[gi];
    end
  endgenerate

  assign bus.pos        = r_pos;
  assign bus.step_pulse = r_step_pulse;
  assign bus.wr_ready   = r_wr_ready;

endmodule
`default_nettype wire

// File: tb/tb_pattern_rotator.sv
`default_nettype none
// ============================================================================
// Module   : tb_pattern_rotator
// Purpose  : Self-checking bench for pattern_rotator: directed scenarios plus
//            randomized control/write traffic against a slot-array model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pattern_rotator;
  localparam int WIDTH = 8;
  localparam int SIZE  = 16;
  localparam int DIV_W = 24;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
`ifdef PATTERN_ROTATOR_BOUNCE_EN
  logic bounce = 1'b0;
`endif

  pattern_rotator_if #(.WIDTH(WIDTH), .SIZE(SIZE), .DIV_W(DIV_W)) bus();

  pattern_rotator #(.WIDTH(WIDTH), .SIZE(SIZE), .DIV_W(DIV_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef PATTERN_ROTATOR_BOUNCE_EN
    .bounce(bounce),
`endif
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: the slot contents as a plain array plus controller state.
  int m_slot [SIZE];
  int m_pos;
  bit m_running;
  bit m_run_seen;   // run level the controller acts on (sampled one edge earlier)
  int m_cnt;
  bit m_wr_ready;
  bit m_pulse;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [WIDTH*SIZE-1:0] model_bus();
    logic [WIDTH*SIZE-1:0] r;
    r = '0;
    for (int i = 0; i < SIZE; i++) r[i*WIDTH +: WIDTH] = WIDTH'(m_slot[i]);
    return r;
  endfunction

  function automatic logic [WIDTH*SIZE-1:0] reset_pattern();
    logic [WIDTH*SIZE-1:0] r;
    for (int i = 0; i < SIZE; i++) r[i*WIDTH +: WIDTH] = WIDTH'(i);
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < SIZE; i++) m_slot[i] = i;
    m_pos = 0; m_running = 0; m_run_seen = 0; m_cnt = 0;
    m_wr_ready = 0; m_pulse = 0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".reg_out"},    bus.reg_out,    model_bus());
    check({tag, ".pos"},        bus.pos,        m_pos);
    check({tag, ".step_pulse"}, bus.step_pulse, m_pulse);
    check({tag, ".wr_ready"},   bus.wr_ready,   m_wr_ready);
  endtask

  // One clock: predict from the current inputs, clock, then compare.
  task automatic tick(input string tag);
    int nxt [SIZE];
    bit step, n_running;
    int n_pos, n_cnt;
    step = m_running ? (m_cnt >= int'(bus.step_div)) : bus.step_req;
    n_pos = m_pos;
    for (int i = 0; i < SIZE; i++) nxt[i] = m_slot[i];
    if (step) begin
      if (bus.dir == 1'b0) begin
        for (int i = 0; i < SIZE; i++) nxt[(i + 1) % SIZE] = m_slot[i];
        n_pos = (m_pos + 1) % SIZE;
      end else begin
        for (int i = 0; i < SIZE; i++) nxt[i] = m_slot[(i + 1) % SIZE];
        n_pos = (m_pos + SIZE - 1) % SIZE;
      end
    end
    if (bus.wr_valid && m_wr_ready && int'(bus.wr_addr) < SIZE)
      nxt[bus.wr_addr] = int'(bus.wr_data);
    n_running = m_running;
    n_cnt = m_cnt;
    if (!m_running) begin
      if (m_run_seen) begin n_running = 1; n_cnt = 0; end
    end else begin
      if (step) n_cnt = 0;
      else if (m_run_seen) n_cnt = m_cnt + 1;
      if (!m_run_seen) n_running = 0;
    end
    @(posedge clk);
    #1;
    m_wr_ready = !m_running;
    m_run_seen = bus.run;
    m_running  = n_running;
    m_cnt      = n_cnt;
    m_pulse    = step;
    m_pos      = n_pos;
    for (int i = 0; i < SIZE; i++) m_slot[i] = nxt[i];
    check_outputs(tag);
  endtask

  task automatic idle_inputs();
    bus.run = 0; bus.dir = 0; bus.step_div = '0; bus.step_req = 0;
    bus.wr_valid = 0; bus.wr_addr = '0; bus.wr_data = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    model_reset();
    check_outputs("reset");
    rst_n = 1'b1;
  endtask

  initial begin
    int t, steps, first, last;
    idle_inputs();

    // Single left step from reset.
    do_reset();
    tick("idle");
    bus.step_req = 1;
    tick("step1");
    bus.step_req = 0;
    check("step1.slot0",  bus.reg_out[0*WIDTH +: WIDTH],  8'h0F);
    check("step1.slot1",  bus.reg_out[1*WIDTH +: WIDTH],  8'h00);
    check("step1.slot15", bus.reg_out[15*WIDTH +: WIDTH], 8'h0E);
    check("step1.pos",    bus.pos, 1);
    check("step1.pulse",  bus.step_pulse, 1'b1);
    tick("step1_after");
    check("step1.pulse_drop", bus.step_pulse, 1'b0);

    // Free-running right rotation with step_div=3, full revolution.
    do_reset();
    bus.run = 1; bus.step_div = 3; bus.dir = 1;
    t = 0; steps = 0; first = -1; last = 0;
    while (steps < 16 && t < 200) begin
      tick("run_div3");
      t++;
      if (bus.step_pulse) begin
        steps++;
        if (first < 0) begin
          first = t;
          check("run.first_step_edge", t, 6);   // tick 1 is the edge sampling run
        end else begin
          check("run.step_spacing", t - last, 4);
        end
        last = t;
      end
    end
    check("run.step_count", steps, 16);
    check("run.rev_reg_out", bus.reg_out, reset_pattern());
    check("run.rev_pos", bus.pos, 0);

    // Write attempted while running is held off until paused.
    for (int i = 0; i < 3; i++) tick("run_more");
    bus.wr_valid = 1; bus.wr_addr = 5; bus.wr_data = 8'hA5;
    for (int i = 0; i < 6; i++) tick("run_wr_blocked");
    check("run.wr_ready_low", bus.wr_ready, 1'b0);
    bus.run = 0;
    t = 0;
    while (!bus.wr_ready && t < 12) begin tick("pause_wait"); t++; end
    check("pause.wr_ready_rise", bus.wr_ready, 1'b1);
    tick("pause_write");
    bus.wr_valid = 0;
    check("pause.slot5", bus.reg_out[5*WIDTH +: WIDTH], 8'hA5);
    tick("pause_hold");

    // Step and write in the same paused cycle.
    do_reset();
    tick("idle2");
    bus.step_req = 1; bus.dir = 0;
    bus.wr_valid = 1; bus.wr_addr = 0; bus.wr_data = 8'h77;
    tick("step_write");
    idle_inputs();
    check("sw.slot0", bus.reg_out[0*WIDTH +: WIDTH], 8'h77);
    check("sw.slot1", bus.reg_out[1*WIDTH +: WIDTH], 8'h00);
    check("sw.pos",   bus.pos, 1);

    // Asynchronous reset in the middle of a fast run.
    bus.run = 1; bus.step_div = 0;
    for (int i = 0; i < 9; i++) tick("fast_run");
    #3;
    rst_n = 1'b0;
    #1;
    check("async.reg_out",  bus.reg_out, reset_pattern());
    check("async.pos",      bus.pos, 0);
    check("async.wr_ready", bus.wr_ready, 1'b0);
    check("async.pulse",    bus.step_pulse, 1'b0);
    do_reset();

    // Randomized traffic.
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 19) == 0) bus.run = ~bus.run;
      if ($urandom_range(0, 7) == 0)  bus.dir = ~bus.dir;
      if ($urandom_range(0, 29) == 0) bus.step_div = DIV_W'($urandom_range(0, 4));
      bus.step_req = ($urandom_range(0, 3) == 0);
      bus.wr_valid = ($urandom_range(0, 2) == 0);
      bus.wr_addr  = 4'($urandom_range(0, SIZE - 1));
      bus.wr_data  = 8'($urandom);
      tick("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
